fabric_packet_crossbar: RTL and testbench



---
 rtl/FabricTypes.sv | 18 +
 rtl/fabric_packet_crossbar_if.sv | 34 +++
 rtl/fabric_rr_arbiter.sv | 72 +++++++
 rtl/fabric_packet_crossbar.sv | 136 +++++++++++++
 tb/tb_fabric_packet_crossbar.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/FabricTypes.sv
// Shared fabric types: egress index width, egress index type and the state encodings
// used by the crossbar's input trackers and per-output arbiters.
package FabricTypes;
    localparam int DEST_WIDTH_DEF = 7;

    typedef logic [DEST_WIDTH_DEF-1:0] egress_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        IN_FIRST = 2'd0,
        IN_BODY  = 2'd1,
        IN_DROP  = 2'd2
    } in_state_e;
endpackage

// File: rtl/fabric_packet_crossbar_if.sv
// Flattened packet-stream bundle between line-card buffers, the crossbar and the exit queues.
// Stream i occupies slice i of every vector; master drives inputs, slave is the crossbar.
interface fabric_packet_crossbar_if
    import FabricTypes::*;
#(
    parameter int NUM_IN     = 4,
    parameter int NUM_OUT    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 12,
    parameter int DEST_WIDTH = DEST_WIDTH_DEF
);
    logic [NUM_IN-1:0]             in_tvalid;
    logic [NUM_IN-1:0]             in_tready;
    logic [NUM_IN*DATA_WIDTH-1:0]  in_tdata;
    logic [NUM_IN*USER_WIDTH-1:0]  in_tuser;
    logic [NUM_IN*DEST_WIDTH-1:0]  in_tdest;
    logic [NUM_IN-1:0]             in_tlast;
    logic [NUM_OUT-1:0]            out_tvalid;
    logic [NUM_OUT-1:0]            out_tready;
    logic [NUM_OUT*DATA_WIDTH-1:0] out_tdata;
    logic [NUM_OUT*USER_WIDTH-1:0] out_tuser;
    logic [NUM_OUT-1:0]            out_tlast;
    logic [NUM_IN-1:0]             drop_pulse;

    modport master (
        output in_tvalid, in_tdata, in_tuser, in_tdest, in_tlast, out_tready,
        input  in_tready, out_tvalid, out_tdata, out_tuser, out_tlast, drop_pulse
    );

    modport slave (
        input  in_tvalid, in_tdata, in_tuser, in_tdest, in_tlast, out_tready,
        output in_tready, out_tvalid, out_tdata, out_tuser, out_tlast, drop_pulse
    );
endinterface

// File: rtl/fabric_rr_arbiter.sv
// Packet-atomic round-robin arbiter for one output: grant registered one cycle after request,
// held until the granted input's tlast beat is accepted (done_i), then one idle cycle.
module fabric_rr_arbiter
    import FabricTypes::*;
#(
    parameter int NUM_IN = 4,
    parameter int IW     = $clog2(NUM_IN)
) (
    input  logic              clk_fabric,
    input  logic              rst,
    input  logic [NUM_IN-1:0] req_i,
    input  logic              done_i,
    output logic              busy_o,
    output logic [IW-1:0]     grant_o
);
    arb_state_e    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW:0]   cand;
    logic [IW-1:0] pick;
    logic          found;

    always_ff @(posedge clk_fabric) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        found   = 1'b0;
        pick    = '0;
        cand    = '0;
        // First requester at or after the pointer, wrapping modulo NUM_IN.
        for (int k = 0; k < NUM_IN; k++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(NUM_IN)) begin
                cand = cand - (IW+1)'(NUM_IN);
            end
            if (!found && req_i[cand[IW-1:0]]) begin
                found = 1'b1;
                pick  = cand[IW-1:0];
            end
        end
        case (state_q)
            ARB_IDLE: begin
                if (found) begin
                    state_d = ARB_BUSY;
                    grant_d = pick;
                    ptr_d   = (pick == IW'(NUM_IN-1)) ? '0 : pick + IW'(1);
                end
            end
            ARB_BUSY: begin
                if (done_i) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign busy_o  = (state_q == ARB_BUSY);
    assign grant_o = grant_q;
endmodule

// File: rtl/fabric_packet_crossbar.sv
// NUM_IN x NUM_OUT packet crossbar: 1-cycle register slice per output, 1 arbitration cycle per packet;
// granted input's in_tready follows its output slice ready; out-of-range tdest is sunk at line rate.
module fabric_packet_crossbar
    import FabricTypes::*;
#(
    parameter int NUM_IN     = 4,
    parameter int NUM_OUT    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 12,
    parameter int DEST_WIDTH = DEST_WIDTH_DEF
) (
    input  logic                     clk_fabric,
    input  logic                     rst,
    fabric_packet_crossbar_if.slave  bus
);
    localparam int IW = $clog2(NUM_IN);

    in_state_e             in_state_q [NUM_IN];
    in_state_e             in_state_d [NUM_IN];
    logic [DEST_WIDTH-1:0] dest_a     [NUM_IN];
    logic [DATA_WIDTH-1:0] data_a     [NUM_IN];
    logic [USER_WIDTH-1:0] user_a     [NUM_IN];
    logic [NUM_IN-1:0]     dest_bad, first_beat, granted, fwd_rdy, drop_rdy, in_acc;
    logic [NUM_IN-1:0]     in_rdy, drop_hit;
    logic [NUM_IN-1:0]     req_m      [NUM_OUT];
    logic [IW-1:0]         grant_a    [NUM_OUT];
    logic [NUM_OUT-1:0]    busy, slice_rdy, load, done;

    logic [NUM_OUT-1:0]            out_tvalid_q, out_tlast_q;
    logic [NUM_OUT*DATA_WIDTH-1:0] out_tdata_q;
    logic [NUM_OUT*USER_WIDTH-1:0] out_tuser_q;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
        assign dest_a[i]     = bus.in_tdest[i*DEST_WIDTH +: DEST_WIDTH];
        assign data_a[i]     = bus.in_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        assign user_a[i]     = bus.in_tuser[i*USER_WIDTH +: USER_WIDTH];
        assign dest_bad[i]   = (dest_a[i] >= DEST_WIDTH'(NUM_OUT));
        assign first_beat[i] = (in_state_q[i] == IN_FIRST);
    end

    for (genvar j = 0; j < NUM_OUT; j++) begin : g_arb
        fabric_rr_arbiter #(
            .NUM_IN (NUM_IN),
            .IW     (IW)
        ) u_arb (
            .clk_fabric (clk_fabric),
            .rst        (rst),
            .req_i      (req_m[j]),
            .done_i     (done[j]),
            .busy_o     (busy[j]),
            .grant_o    (grant_a[j])
        );
    end

    always_comb begin : fwd_path
        granted   = '0;
        fwd_rdy   = '0;
        slice_rdy = '0;
        load      = '0;
        done      = '0;
        for (int j = 0; j < NUM_OUT; j++) begin
            slice_rdy[j] = !out_tvalid_q[j] || bus.out_tready[j];
            if (busy[j]) begin
                granted[grant_a[j]] = 1'b1;
                fwd_rdy[grant_a[j]] = slice_rdy[j];
                load[j]             = bus.in_tvalid[grant_a[j]] && slice_rdy[j];
                done[j]             = load[j] && bus.in_tlast[grant_a[j]];
            end
        end
    end

    // Dropped packets never touch an arbiter; the first beat is sunk in the cycle it appears.
    always_comb begin : in_path
        in_rdy   = '0;
        drop_hit = '0;
        drop_rdy = '0;
        in_acc   = '0;
        for (int j = 0; j < NUM_OUT; j++) begin
            req_m[j] = '0;
        end
        for (int i = 0; i < NUM_IN; i++) begin
            in_state_d[i] = in_state_q[i];
            drop_rdy[i]   = (in_state_q[i] == IN_DROP)
                            || (first_beat[i] && bus.in_tvalid[i] && dest_bad[i]);
            in_rdy[i]     = !rst && (fwd_rdy[i] || drop_rdy[i]);
            in_acc[i]     = bus.in_tvalid[i] && in_rdy[i];
            drop_hit[i]   = in_acc[i] && bus.in_tlast[i] && drop_rdy[i];
            if (in_acc[i]) begin
                if (bus.in_tlast[i]) begin
                    in_state_d[i] = IN_FIRST;
                end else if (drop_rdy[i]) begin
                    in_state_d[i] = IN_DROP;
                end else begin
                    in_state_d[i] = IN_BODY;
                end
            end
            for (int j = 0; j < NUM_OUT; j++) begin
                req_m[j][i] = bus.in_tvalid[i] && first_beat[i] && !granted[i]
                              && (dest_a[i] == DEST_WIDTH'(j));
            end
        end
    end

    always_ff @(posedge clk_fabric) begin
        for (int i = 0; i < NUM_IN; i++) begin
            in_state_q[i] <= rst ? IN_FIRST : in_state_d[i];
        end
    end

    always_ff @(posedge clk_fabric) begin
        if (rst) begin
            out_tvalid_q <= '0;
            out_tlast_q  <= '0;
            out_tdata_q  <= '0;
            out_tuser_q  <= '0;
        end else begin
            for (int j = 0; j < NUM_OUT; j++) begin
                if (slice_rdy[j]) begin
                    out_tvalid_q[j] <= load[j];
                    if (load[j]) begin
                        out_tdata_q[j*DATA_WIDTH +: DATA_WIDTH] <= data_a[grant_a[j]];
                        out_tuser_q[j*USER_WIDTH +: USER_WIDTH] <= user_a[grant_a[j]];
                        out_tlast_q[j]                          <= bus.in_tlast[grant_a[j]];
                    end
                end
            end
        end
    end

    assign bus.in_tready  = in_rdy;
    assign bus.drop_pulse = drop_hit;
    assign bus.out_tvalid = out_tvalid_q;
    assign bus.out_tdata  = out_tdata_q;
    assign bus.out_tuser  = out_tuser_q;
    assign bus.out_tlast  = out_tlast_q;
endmodule

// File: tb/tb_fabric_packet_crossbar.sv
// Directed bench for fabric_packet_crossbar: routing, latency, round-robin order, parallel
// outputs, backpressure, drop path and mid-packet reset, all against hand-computed values.
module tb_fabric_packet_crossbar;
    import FabricTypes::*;

    localparam int NI = 4;
    localparam int NO = 4;
    localparam int DW = 64;
    localparam int UW = 12;
    localparam int TW = 7;
    localparam logic [11:0] USER0 = 12'h0A0;

    typedef struct {
        logic [63:0] d;
        logic [11:0] u;
        logic        l;
        int          c;
    } beat_t;

    logic  clk_fabric = 1'b0;
    logic  rst        = 1'b1;
    int    cyc        = 0;
    int    n_total    = 0;
    int    n_pass     = 0;
    beat_t mon_q [NO][$];
    beat_t mon_bt;

    fabric_packet_crossbar_if #(.NUM_IN(NI), .NUM_OUT(NO), .DATA_WIDTH(DW),
                                .USER_WIDTH(UW), .DEST_WIDTH(TW)) bus ();

    fabric_packet_crossbar #(.NUM_IN(NI), .NUM_OUT(NO), .DATA_WIDTH(DW),
                             .USER_WIDTH(UW), .DEST_WIDTH(TW)) dut (
        .clk_fabric (clk_fabric),
        .rst        (rst),
        .bus        (bus)
    );

    always #5 clk_fabric = ~clk_fabric;
    always @(posedge clk_fabric) cyc <= cyc + 1;

    always @(negedge clk_fabric) begin
        for (int j = 0; j < NO; j++) begin
            if (!rst && bus.out_tvalid[j] && bus.out_tready[j]) begin
                mon_bt.d = bus.out_tdata[j*DW +: DW];
                mon_bt.u = bus.out_tuser[j*UW +: UW];
                mon_bt.l = bus.out_tlast[j];
                mon_bt.c = cyc;
                mon_q[j].push_back(mon_bt);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input int p, input egress_t dest, input logic [63:0] data, input logic last);
        bus.in_tvalid[p]         = 1'b1;
        bus.in_tdata[p*DW +: DW] = data;
        bus.in_tuser[p*UW +: UW] = 12'(USER0 + 12'(p));
        bus.in_tdest[p*TW +: TW] = dest;
        bus.in_tlast[p]          = last;
    endtask

    task automatic idle(input int p);
        bus.in_tvalid[p] = 1'b0;
        bus.in_tlast[p]  = 1'b0;
    endtask

    // Call at posedge+1; returns at posedge+1 after the last beat has been accepted.
    task automatic send_pkt(input int p, input egress_t dest, input int n, input logic [63:0] base);
        for (int b = 0; b < n; b++) begin
            logic acc;
            int   w;
            drive(p, dest, base + 64'(b), (b == n - 1));
            acc = 1'b0;
            w   = 0;
            while (!acc && w < 100) begin
                @(negedge clk_fabric);
                acc = bus.in_tready[p];
                w++;
                if (!acc) @(posedge clk_fabric);
            end
            check("beat_accepted", 64'(acc), 64'd1);
            @(posedge clk_fabric);
            #1;
        end
        idle(p);
    endtask

    task automatic expect_pkt(input string tag, input int j, input int p, input int n, input logic [63:0] base);
        for (int b = 0; b < n && mon_q[j].size() > 0; b++) begin
            beat_t bt;
            bt = mon_q[j].pop_front();
            check({tag, "_data"}, bt.d, base + 64'(b));
            check({tag, "_last"}, 64'(bt.l), 64'(b == n - 1));
            check({tag, "_user"}, 64'(bt.u), 64'(USER0 + 12'(p)));
        end
    endtask

    task automatic clear_mon();
        for (int j = 0; j < NO; j++) mon_q[j].delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int t0;
        int last_c;
        int first_c;
        bus.in_tvalid  = '0;
        bus.in_tdata   = '0;
        bus.in_tuser   = '0;
        bus.in_tdest   = '0;
        bus.in_tlast   = '0;
        bus.out_tready = '1;

        // Reset values
        repeat (2) @(posedge clk_fabric);
        @(negedge clk_fabric);
        check("rst_out_tvalid", 64'(bus.out_tvalid), 64'd0);
        check("rst_out_tdata", bus.out_tdata[63:0], 64'd0);
        check("rst_out_tlast", 64'(bus.out_tlast), 64'd0);
        check("rst_in_tready", 64'(bus.in_tready), 64'd0);
        check("rst_drop", 64'(bus.drop_pulse), 64'd0);
        @(posedge clk_fabric);
        #1 rst = 1'b0;

        // Single packet in0 -> out2
        @(posedge clk_fabric); #1;
        drive(0, 7'd2, 64'h11, 1'b0);
        @(negedge clk_fabric);
        check("t1_arb_cycle_rdy", 64'(bus.in_tready[0]), 64'd0);
        @(posedge clk_fabric); #1;
        @(negedge clk_fabric);
        check("t1_grant_rdy", 64'(bus.in_tready[0]), 64'd1);
        check("t1_out_not_yet", 64'(bus.out_tvalid), 64'd0);
        @(posedge clk_fabric); #1;
        drive(0, 7'd2, 64'h22, 1'b0);
        @(negedge clk_fabric);
        check("t1_vld_T2", 64'(bus.out_tvalid), 64'b0100);
        check("t1_beat0", bus.out_tdata[2*DW +: DW], 64'h11);
        @(posedge clk_fabric); #1;
        drive(0, 7'd2, 64'h33, 1'b1);
        @(negedge clk_fabric);
        check("t1_beat1", bus.out_tdata[2*DW +: DW], 64'h22);
        check("t1_beat1_last", 64'(bus.out_tlast[2]), 64'd0);
        @(posedge clk_fabric); #1;
        idle(0);
        @(negedge clk_fabric);
        check("t1_vld_beat2", 64'(bus.out_tvalid), 64'b0100);
        check("t1_beat2", bus.out_tdata[2*DW +: DW], 64'h33);
        check("t1_beat2_last", 64'(bus.out_tlast[2]), 64'd1);
        check("t1_user", 64'(bus.out_tuser[2*UW +: UW]), 64'(USER0));
        @(posedge clk_fabric); #1;
        @(negedge clk_fabric);
        check("t1_drained", 64'(bus.out_tvalid), 64'd0);
        @(posedge clk_fabric); #1;
        clear_mon();

        // Contention on out1: two rounds, both expected in0, in1, in2, in3
        for (int r = 0; r < 2; r++) begin
            fork
                send_pkt(0, 7'd1, 2, 64'h2000 + 64'(r * 256));
                send_pkt(1, 7'd1, 2, 64'h2010 + 64'(r * 256));
                send_pkt(2, 7'd1, 2, 64'h2020 + 64'(r * 256));
                send_pkt(3, 7'd1, 2, 64'h2030 + 64'(r * 256));
            join
            repeat (3) @(posedge clk_fabric);
            #1;
            check("t2_count", 64'(mon_q[1].size()), 64'd8);
            check("t2_others_idle", 64'(mon_q[0].size() + mon_q[2].size() + mon_q[3].size()), 64'd0);
            for (int p = 0; p < NI; p++) begin
                expect_pkt("t2_rr", 1, p, 2, 64'h2000 + 64'(r * 256) + 64'(p * 16));
            end
            clear_mon();
        end

        // Parallel in0->out3 and in3->out0
        t0 = cyc;
        fork
            send_pkt(0, 7'd3, 8, 64'h3000);
            send_pkt(3, 7'd0, 8, 64'h3300);
        join
        repeat (3) @(posedge clk_fabric);
        #1;
        check("t3_cnt_out3", 64'(mon_q[3].size()), 64'd8);
        check("t3_cnt_out0", 64'(mon_q[0].size()), 64'd8);
        first_c = (mon_q[3].size() > 0) ? mon_q[3][0].c - t0 : -1;
        check("t3_first_lat", 64'(first_c), 64'd2);
        last_c = (mon_q[3].size() > 0) ? mon_q[3][$].c - t0 : -1;
        check("t3_out3_done", 64'(last_c), 64'd9);
        last_c = (mon_q[0].size() > 0) ? mon_q[0][$].c - t0 : -1;
        check("t3_out0_done", 64'(last_c), 64'd9);
        expect_pkt("t3_out3", 3, 0, 8, 64'h3000);
        expect_pkt("t3_out0", 0, 3, 8, 64'h3300);
        clear_mon();

        // Backpressure on out2 while in1 streams 6 beats
        fork
            send_pkt(1, 7'd2, 6, 64'h4000);
            begin
                int g;
                g = 0;
                do begin
                    @(negedge clk_fabric);
                    g++;
                end while (!bus.out_tvalid[2] && g < 50);
                check("t4_first_vld", 64'(bus.out_tvalid[2]), 64'd1);
                @(posedge clk_fabric); #1;
                bus.out_tready[2] = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk_fabric);
                    check("t4_hold_data", bus.out_tdata[2*DW +: DW], 64'h4001);
                    check("t4_hold_vld", 64'(bus.out_tvalid[2]), 64'd1);
                    check("t4_src_rdy", 64'(bus.in_tready[1]), 64'd0);
                    @(posedge clk_fabric); #1;
                end
                bus.out_tready[2] = 1'b1;
            end
        join
        repeat (3) @(posedge clk_fabric);
        #1;
        check("t4_count", 64'(mon_q[2].size()), 64'd6);
        expect_pkt("t4_pkt", 2, 1, 6, 64'h4000);
        clear_mon();

        // Drop: 4-beat packet to tdest=7, then single-beat packet to tdest=NUM_OUT
        for (int b = 0; b < 4; b++) begin
            drive(1, 7'd7, 64'h5000 + 64'(b), (b == 3));
            @(negedge clk_fabric);
            check("t5_drop_rdy", 64'(bus.in_tready[1]), 64'd1);
            check("t5_drop_pulse", 64'(bus.drop_pulse), (b == 3) ? 64'b0010 : 64'd0);
            check("t5_no_out", 64'(bus.out_tvalid), 64'd0);
            @(posedge clk_fabric); #1;
        end
        idle(1);
        drive(2, 7'd4, 64'h5100, 1'b1);
        @(negedge clk_fabric);
        check("t5_single_rdy", 64'(bus.in_tready[2]), 64'd1);
        check("t5_single_pulse", 64'(bus.drop_pulse), 64'b0100);
        @(posedge clk_fabric); #1;
        idle(2);
        @(negedge clk_fabric);
        check("t5_pulse_gone", 64'(bus.drop_pulse), 64'd0);
        check("t5_no_out_after", 64'(mon_q[0].size() + mon_q[1].size() + mon_q[2].size() + mon_q[3].size()), 64'd0);
        @(posedge clk_fabric); #1;

        // Reset mid-packet on out0 (arbiter pointer advanced past in0 beforehand)
        drive(0, 7'd0, 64'h6A00, 1'b0);
        @(posedge clk_fabric); #1;
        @(posedge clk_fabric); #1;
        drive(0, 7'd0, 64'h6A01, 1'b0);
        @(negedge clk_fabric);
        check("t6_pre_vld", 64'(bus.out_tvalid[0]), 64'd1);
        @(posedge clk_fabric); #1;
        rst = 1'b1;
        idle(0);
        @(negedge clk_fabric);
        check("t6_rst_rdy", 64'(bus.in_tready), 64'd0);
        @(posedge clk_fabric); #1;
        rst = 1'b0;
        @(negedge clk_fabric);
        check("t6_out_invalid", 64'(bus.out_tvalid), 64'd0);
        check("t6_out_data_zero", bus.out_tdata[63:0], 64'd0);
        @(posedge clk_fabric); #1;
        clear_mon();
        fork
            send_pkt(3, 7'd0, 2, 64'h6300);
            send_pkt(0, 7'd0, 2, 64'h6000);
        join
        repeat (3) @(posedge clk_fabric);
        #1;
        check("t6_count", 64'(mon_q[0].size()), 64'd4);
        expect_pkt("t6_first_in0", 0, 0, 2, 64'h6000);
        expect_pkt("t6_then_in3", 0, 3, 2, 64'h6300);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
